snake_core: RTL and testbench

//  - Snake body engine for a 640x480 VGA snake game on a 40x30 grid of 16x16-pixel cells.
//  - Holds the direction register, segment count and 16 segment coordinates.
//  - Advances the snake one cell per speed tick and reports whether the current scan pixel lies on the snake.
//  - Sits between the key/switch inputs, the food/collision logic (add_cube, died) and the VGA pixel mux.

---
 rtl/snake_pkg.sv | 53 +++++
 rtl/snake_if.sv | 33 +++
 rtl/snake_tick.sv | 37 +++
 rtl/snake_core.sv | 116 +++++++++++
 tb/tb_snake_core.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake body engine.
//   - Direction encoding, grid geometry and segment count.
//   - Initial snake coordinates.
//   - Cell helpers: one-cell move with wrap-around, and the reset layout.
package snake_pkg;

  localparam int unsigned GRID_W  = 40;
  localparam int unsigned GRID_H  = 30;
  localparam int unsigned MAX_SEG = 16;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef logic [5:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } cell_t;

  localparam coord_t     INIT_X0       = 6'd10;
  localparam coord_t     INIT_X1       = 6'd9;
  localparam coord_t     INIT_X2       = 6'd8;
  localparam coord_t     INIT_Y        = 6'd10;
  localparam logic [3:0] INIT_CUBE_NUM = 4'd3;

  // Move one cell in dir, wrapping at the grid edges.
  function automatic cell_t step_cell(cell_t c, logic [1:0] dir);
    cell_t n;
    n = c;
    case (dir)
      DIR_UP:    n.y = (c.y == '0) ? coord_t'(GRID_H - 1) : c.y - 6'd1;
      DIR_DOWN:  n.y = (c.y == coord_t'(GRID_H - 1)) ? '0 : c.y + 6'd1;
      DIR_LEFT:  n.x = (c.x == '0) ? coord_t'(GRID_W - 1) : c.x - 6'd1;
      DIR_RIGHT: n.x = (c.x == coord_t'(GRID_W - 1)) ? '0 : c.x + 6'd1;
      default:   n = c;
    endcase
    return n;
  endfunction

  // Reset-time position of segment idx.
  function automatic cell_t init_cell(int unsigned idx);
    cell_t c;
    c = '0;
    if (idx == 0) c = '{x: INIT_X0, y: INIT_Y};
    if (idx == 1) c = '{x: INIT_X1, y: INIT_Y};
    if (idx == 2) c = '{x: INIT_X2, y: INIT_Y};
    return c;
  endfunction

endpackage

// File: rtl/snake_if.sv
// Signal bundle between the game logic / VGA scan and the snake engine.
//   master: drives speed switches, keys, scan position, add_cube, died;
//           receives head position, snake_show, hit_body.
//   slave:  the snake engine (snake_core).
interface snake_if;
  logic       sw2;
  logic       sw1;
  logic       sw0;
  logic       key0_right;
  logic       key1_left;
  logic       key2_down;
  logic       key3_up;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic       add_cube;
  logic       died;
  logic [5:0] head_x;
  logic [5:0] head_y;
  logic       snake_show;
  logic       hit_body;

  modport master (
    output sw2, sw1, sw0, key0_right, key1_left, key2_down, key3_up,
    output pos_x, pos_y, add_cube, died,
    input  head_x, head_y, snake_show, hit_body
  );

  modport slave (
    input  sw2, sw1, sw0, key0_right, key1_left, key2_down, key3_up,
    input  pos_x, pos_y, add_cube, died,
    output head_x, head_y, snake_show, hit_body
  );
endinterface

// File: rtl/snake_tick.sv
// Speed counter: issues a one-cycle step pulse every STEP_UNIT*(8-spd) cycles.
//   clk    in  system clock
//   rst    in  synchronous active-high reset
//   clr_i  in  synchronous counter clear (game over)
//   spd_i  in  speed select, 7 fastest, 0 slowest
//   step_o out step pulse, high in the last cycle of each period
module snake_tick #(
  parameter int unsigned STEP_UNIT = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic [2:0] spd_i,
  output logic       step_o
);

  localparam int unsigned CntW = $clog2(STEP_UNIT * 8);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] limit;

  always_comb begin
    limit  = CntW'(STEP_UNIT * (32'd8 - 32'(spd_i)) - 32'd1);
    // >= so that switching to a faster speed never overruns the new limit
    step_o = (cnt_q >= limit);
    cnt_d  = step_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/snake_core.sv
// Snake body engine for a 40x30 grid of 16x16-pixel cells.
//   clk  in  system clock
//   rst  in  synchronous active-high reset
//   bus  snake_if.slave: keys, speed switches, scan position, add_cube, died in;
//        head_x/head_y, snake_show, hit_body out
// Holds direction, segment count and 16 segment cells; steps one cell per speed
// tick and flags scan pixels on the snake plus head/body collisions.
module snake_core
  import snake_pkg::*;
#(
  parameter int unsigned STEP_UNIT = 2_500_000
) (
  input logic    clk,
  input logic    rst,
  snake_if.slave bus
);

  logic [1:0] direct_q, direct_d;
  logic [1:0] last_dir_q, last_dir_d;
  logic [3:0] cube_num_q, cube_num_d;
  logic       add_q, add_d;
  cell_t      seg_q [MAX_SEG];
  cell_t      seg_d [MAX_SEG];
  logic       show_q, show_d;
  logic       hit_q, hit_d;

  logic       step;
  logic       init;
  logic       key_vld;
  logic [1:0] key_dir;
  coord_t     px, py;
  logic       unused_pos;

  assign init       = rst | bus.died;
  assign px         = bus.pos_x[9:4];
  assign py         = bus.pos_y[9:4];
  assign unused_pos = ^{bus.pos_x[3:0], bus.pos_y[3:0]};

  snake_tick #(
    .STEP_UNIT(STEP_UNIT)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clr_i (bus.died),
    .spd_i ({bus.sw2, bus.sw1, bus.sw0}),
    .step_o(step)
  );

  // Key decode: up > down > left > right; keys on the axis of the last executed
  // step (same or reverse) leave the direction unchanged.
  always_comb begin
    key_vld = bus.key3_up | bus.key2_down | bus.key1_left | bus.key0_right;
    if (bus.key3_up)        key_dir = DIR_UP;
    else if (bus.key2_down) key_dir = DIR_DOWN;
    else if (bus.key1_left) key_dir = DIR_LEFT;
    else                    key_dir = DIR_RIGHT;

    direct_d = direct_q;
    if (key_vld && (key_dir[1] != last_dir_q[1])) direct_d = key_dir;
  end

  always_comb begin
    last_dir_d = last_dir_q;
    seg_d      = seg_q;
    if (step) begin
      last_dir_d = direct_q;
      for (int i = MAX_SEG - 1; i >= 1; i--) seg_d[i] = seg_q[i-1];
      seg_d[0] = step_cell(seg_q[0], direct_q);
    end
  end

  // Growth on the add_cube rising edge, saturating at 15.
  always_comb begin
    add_d      = bus.add_cube;
    cube_num_d = cube_num_q;
    if (bus.add_cube && !add_q && (cube_num_q != 4'd15)) cube_num_d = cube_num_q + 4'd1;
  end

  // Pixel and collision compare over active segments (index < cube_num).
  always_comb begin
    show_d = 1'b0;
    hit_d  = 1'b0;
    for (int i = 0; i < MAX_SEG; i++) begin
      if (4'(i) < cube_num_q) begin
        if ((seg_q[i].x == px) && (seg_q[i].y == py)) show_d = 1'b1;
        if ((i != 0) && (seg_q[i] == seg_q[0]))        hit_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      direct_q   <= DIR_RIGHT;
      last_dir_q <= DIR_RIGHT;
      cube_num_q <= INIT_CUBE_NUM;
      add_q      <= 1'b0;
      show_q     <= 1'b0;
      hit_q      <= 1'b0;
      for (int i = 0; i < MAX_SEG; i++) seg_q[i] <= init_cell(i);
    end else begin
      direct_q   <= direct_d;
      last_dir_q <= last_dir_d;
      cube_num_q <= cube_num_d;
      add_q      <= add_d;
      show_q     <= show_d;
      hit_q      <= hit_d;
      for (int i = 0; i < MAX_SEG; i++) seg_q[i] <= seg_d[i];
    end
  end

  assign bus.head_x     = seg_q[0].x;
  assign bus.head_y     = seg_q[0].y;
  assign bus.snake_show = show_q;
  assign bus.hit_body   = hit_q;

endmodule

// File: tb/tb_snake_core.sv
module tb_snake_core;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  snake_if bus ();

  snake_core #(
    .STEP_UNIT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hxy(input int x, input int y);
    return 32'(x * 64 + y);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // k: 0 right, 1 left, 2 down, 3 up
  task automatic pulse_key(input int k);
    bus.key0_right = (k == 0);
    bus.key1_left  = (k == 1);
    bus.key2_down  = (k == 2);
    bus.key3_up    = (k == 3);
    tick(1);
    bus.key0_right = 1'b0;
    bus.key1_left  = 1'b0;
    bus.key2_down  = 1'b0;
    bus.key3_up    = 1'b0;
  endtask

  task automatic pulse_add();
    bus.add_cube = 1'b1;
    tick(1);
    bus.add_cube = 1'b0;
    tick(1);
  endtask

  // Bounded wait for the head to move, then compare to the scoreboard entry.
  task automatic wait_head(input string tag);
    logic [11:0] old;
    int n;
    old = {bus.head_x, bus.head_y};
    n = 0;
    while (({bus.head_x, bus.head_y} === old) && (n < 40)) begin
      tick(1);
      n++;
    end
    chk(tag, {20'd0, bus.head_x, bus.head_y}, exp_q.pop_front());
  endtask

  task automatic show_chk(input string tag, input int x, input int y, input logic e);
    bus.pos_x = 10'(x);
    bus.pos_y = 10'(y);
    exp_q.push_back({31'd0, e});
    tick(1);
    chk(tag, {31'd0, bus.snake_show}, exp_q.pop_front());
  endtask

  initial begin
    int x;
    int y;
    rst = 1'b1;
    {bus.sw2, bus.sw1, bus.sw0} = 3'd0;
    bus.key0_right = 1'b0;
    bus.key1_left  = 1'b0;
    bus.key2_down  = 1'b0;
    bus.key3_up    = 1'b0;
    bus.pos_x      = '0;
    bus.pos_y      = '0;
    bus.add_cube   = 1'b0;
    bus.died       = 1'b0;

    // Reset state and step latency at spd=0
    tick(3);
    rst = 1'b0;
    chk("rst_dir", 32'(dut.direct_q), 32'd3);
    chk("rst_cube", 32'(dut.cube_num_q), 32'd3);
    chk("rst_head", {20'd0, bus.head_x, bus.head_y}, hxy(10, 10));
    chk("rst_show", {31'd0, bus.snake_show}, 32'd0);
    chk("rst_hit", {31'd0, bus.hit_body}, 32'd0);
    exp_q.push_back(hxy(11, 10));
    tick(16);
    chk("step16", {20'd0, bus.head_x, bus.head_y}, exp_q.pop_front());
    exp_q.push_back(hxy(12, 10));
    tick(16);
    chk("step32", {20'd0, bus.head_x, bus.head_y}, exp_q.pop_front());

    // Reverse key ignored, perpendicular accepted
    pulse_key(1);
    chk("left_vs_right", 32'(dut.direct_q), 32'd3);
    pulse_key(2);
    chk("down_dir", 32'(dut.direct_q), 32'd1);
    exp_q.push_back(hxy(12, 11));
    wait_head("down_step");

    pulse_key(3);
    chk("up_vs_down", 32'(dut.direct_q), 32'd1);
    pulse_key(1);
    chk("left_dir", 32'(dut.direct_q), 32'd2);
    exp_q.push_back(hxy(11, 11));
    wait_head("left_step");

    // Growth: held level counts once, then saturation
    bus.add_cube = 1'b1;
    tick(3);
    chk("grow_held", 32'(dut.cube_num_q), 32'd4);
    bus.add_cube = 1'b0;
    tick(1);
    chk("grow_once", 32'(dut.cube_num_q), 32'd4);
    for (int i = 0; i < 15; i++) pulse_add();
    chk("grow_sat", 32'(dut.cube_num_q), 32'd15);

    // died restores the initial snake
    bus.died = 1'b1;
    tick(2);
    chk("died_head", {20'd0, bus.head_x, bus.head_y}, hxy(10, 10));
    chk("died_cube", 32'(dut.cube_num_q), 32'd3);
    chk("died_dir", 32'(dut.direct_q), 32'd3);
    bus.died = 1'b0;

    // Pixel compare on the stationary initial snake
    show_chk("show_head", 160, 160, 1'b1);
    show_chk("show_origin", 0, 0, 1'b0);
    show_chk("show_seg1", 144, 160, 1'b1);
    show_chk("show_seg2", 128, 175, 1'b1);
    show_chk("show_inactive", 112, 160, 1'b0);
    show_chk("show_row11", 160, 176, 1'b0);
    show_chk("show_cell_edge", 175, 175, 1'b1);
    exp_q.push_back(hxy(11, 10));
    wait_head("resume");

    // Five-segment loop back onto the body
    pulse_add();
    pulse_add();
    pulse_key(2);
    exp_q.push_back(hxy(11, 11));
    wait_head("loop_down");
    pulse_key(1);
    exp_q.push_back(hxy(10, 11));
    wait_head("loop_left");
    chk("no_hit", {31'd0, bus.hit_body}, 32'd0);
    pulse_key(3);
    exp_q.push_back(hxy(10, 10));
    wait_head("loop_up");
    tick(1);
    chk("hit_body", {31'd0, bus.hit_body}, 32'd1);

    // Fastest speed, wrap in x then in y
    {bus.sw2, bus.sw1, bus.sw0} = 3'd7;
    bus.died = 1'b1;
    tick(1);
    bus.died = 1'b0;
    x = 10;
    for (int k = 0; k < 32; k++) begin
      x = (x + 1) % 40;
      exp_q.push_back(hxy(x, 10));
      wait_head($sformatf("wrap_x%0d", k));
    end
    pulse_key(3);
    y = 10;
    for (int k = 0; k < 12; k++) begin
      y = (y == 0) ? 29 : y - 1;
      exp_q.push_back(hxy(x, y));
      wait_head($sformatf("wrap_y%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
